spsram_port_arb: RTL

- Sequences all accesses to the single-port 128-bit unified program/data SRAM (524288 x 128) behind the 128-bit AXI slave.
- Three requesters share the one port:
  - ld: backdoor loader, used for preload and wipe.
  - wr: AXI write engine.
  - rd: AXI read engine.
- Arbitration is at burst granularity. The arbiter owns address generation, byte-strobe expansion and read-data return.

---
 rtl/spsram_arb_pkg.sv | 25 ++
 rtl/spsram_arb_pick.sv | 26 ++
 rtl/spsram_port_arb.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/spsram_arb_pkg.sv
// Shared types and default widths for the unified SRAM port arbiter.
// Imported by the owner picker and the arbiter top.
package spsram_arb_pkg;

    localparam int DEF_ADDR_W = 19;
    localparam int DEF_DATA_W = 128;
    localparam int DEF_LEN_W  = 4;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_LD,
        OWN_WR,
        OWN_RD
    } owner_e;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_BURST
    } state_e;

    function automatic logic owner_writes(input owner_e own);
        return (own == OWN_LD) || (own == OWN_WR);
    endfunction

endpackage

// File: rtl/spsram_arb_pick.sv
// Owner select: loader first, then round-robin between write and read.
// Purely combinational; the caller decides when the result is latched.
module spsram_arb_pick
    import spsram_arb_pkg::*;
(
    input  logic   ld_req,
    input  logic   wr_req,
    input  logic   rd_req,
    input  logic   rr_rd,
    output owner_e owner
);

    always_comb begin
        owner = OWN_NONE;
        if (ld_req) begin
            owner = OWN_LD;
        end else if (wr_req && rd_req) begin
            owner = rr_rd ? OWN_RD : OWN_WR;
        end else if (wr_req) begin
            owner = OWN_WR;
        end else if (rd_req) begin
            owner = OWN_RD;
        end
    end

endmodule

// File: rtl/spsram_port_arb.sv
// Burst-granular arbiter for the single-port unified program/data SRAM.
// Owns address generation, strobe expansion and read-data return.
module spsram_port_arb
    import spsram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                clk,
    input  logic                rst_b,

    input  logic                ld_req,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [LEN_W-1:0]    ld_len,
    input  logic [DATA_W-1:0]   ld_wdata,
    output logic                ld_gnt,

    input  logic                wr_req,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [LEN_W-1:0]    wr_len,
    input  logic [DATA_W-1:0]   wr_wdata,
    input  logic [DATA_W/8-1:0] wr_wstrb,
    output logic                wr_gnt,

    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic [LEN_W-1:0]    rd_len,
    output logic                rd_gnt,
    output logic                rd_rvalid,
    output logic [DATA_W-1:0]   rd_rdata,
    output logic                rd_rlast,

    output logic                mem_cen_b,
    output logic                mem_gwen_b,
    output logic [DATA_W-1:0]   mem_wen_b,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_din,
    input  logic [DATA_W-1:0]   mem_dout,

    output logic                arb_busy
);

    localparam int STRB_W = DATA_W / 8;

    state_e              state_q;
    owner_e              owner_q;
    owner_e              pick;
    logic                rr_rd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    cnt_q;
    logic                rvalid_q;
    logic                rlast_q;

    logic                own_req;
    logic                beat;
    logic                last_cnt;
    logic                is_write;
    logic [STRB_W-1:0]   strb;
    logic [DATA_W-1:0]   wdata;
    logic                wr_access;
    logic                rd_access;
    logic [ADDR_W-1:0]   start_addr;
    logic [LEN_W-1:0]    start_len;

    spsram_arb_pick u_pick (
        .ld_req (ld_req),
        .wr_req (wr_req),
        .rd_req (rd_req),
        .rr_rd  (rr_rd_q),
        .owner  (pick)
    );

    always_comb begin
        own_req = 1'b0;
        unique case (owner_q)
            OWN_LD:  own_req = ld_req;
            OWN_WR:  own_req = wr_req;
            OWN_RD:  own_req = rd_req;
            default: own_req = 1'b0;
        endcase
    end

    assign beat     = (state_q == ST_BURST) && own_req;
    assign last_cnt = (cnt_q == len_q);

    assign ld_gnt = beat && (owner_q == OWN_LD);
    assign wr_gnt = beat && (owner_q == OWN_WR);
    assign rd_gnt = beat && (owner_q == OWN_RD);

    // Loader always writes whole words; an all-zero strobe skips the access.
    assign is_write  = owner_writes(owner_q);
    assign strb      = (owner_q == OWN_LD) ? '1 : wr_wstrb;
    assign wdata     = (owner_q == OWN_LD) ? ld_wdata : wr_wdata;
    assign wr_access = beat && is_write && (|strb);
    assign rd_access = beat && (owner_q == OWN_RD);

    assign mem_cen_b  = !(wr_access || rd_access);
    assign mem_gwen_b = !wr_access;
    assign mem_addr   = addr_q;
    assign mem_din    = wr_access ? wdata : '0;

    always_comb begin
        mem_wen_b = '1;
        if (wr_access) begin
            for (int k = 0; k < STRB_W; k++) begin
                mem_wen_b[8*k +: 8] = {8{~strb[k]}};
            end
        end
    end

    always_comb begin
        start_addr = '0;
        start_len  = '0;
        unique case (pick)
            OWN_LD: begin
                start_addr = ld_addr;
                start_len  = ld_len;
            end
            OWN_WR: begin
                start_addr = wr_addr;
                start_len  = wr_len;
            end
            OWN_RD: begin
                start_addr = rd_addr;
                start_len  = rd_len;
            end
            default: begin
                start_addr = '0;
                start_len  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
            rr_rd_q <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pick != OWN_NONE) begin
                        owner_q <= pick;
                        addr_q  <= start_addr;
                        len_q   <= start_len;
                        cnt_q   <= '0;
                        state_q <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (beat) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        cnt_q  <= cnt_q + LEN_W'(1);
                        if (last_cnt) begin
                            state_q <= ST_IDLE;
                            owner_q <= OWN_NONE;
                            // Loader bursts leave the wr/rd fairness untouched.
                            if (owner_q == OWN_WR) begin
                                rr_rd_q <= 1'b1;
                            end else if (owner_q == OWN_RD) begin
                                rr_rd_q <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            rvalid_q <= rd_access;
            rlast_q  <= rd_access && last_cnt;
        end
    end

    // Data comes straight from the macro; only its own one-cycle latency.
    assign rd_rvalid = rvalid_q;
    assign rd_rlast  = rlast_q;
    assign rd_rdata  = rvalid_q ? mem_dout : '0;
    assign arb_busy  = (state_q == ST_BURST);

endmodule
